zbt_bitstream_writer: RTL and testbench



---
 rtl/zbt_bitstream_writer_pkg.sv | 23 ++
 rtl/bitstream_wr_fifo_ram.sv | 33 +++
 rtl/zbt_bitstream_writer.sv | 191 +++++++++++++++++++
 tb/tb_zbt_bitstream_writer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_bitstream_writer_pkg.sv
// rtl/zbt_bitstream_writer_pkg.sv - shared parameters and byte-lane helper for the ZBT bitstream writer
package zbt_bitstream_writer_pkg;

  localparam int BITSTR_BUFFER_ADDR_WIDTH = 4;
  localparam int BITSTR_BUFFER_SLACK      = 2;
  localparam int BITSTR_ZBT_ADDR_WIDTH    = 19;

  // Drop a byte into its MSB-first lane; lane 0 is bits [31:24], matching the reader.
  function automatic logic [31:0] set_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    case (lane)
      2'd0: result[31:24] = data;
      2'd1: result[23:16] = data;
      2'd2: result[15:8]  = data;
      2'd3: result[7:0]   = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/bitstream_wr_fifo_ram.sv
// rtl/bitstream_wr_fifo_ram.sv - simple dual-port word buffer, write port A, registered read port B
module bitstream_wr_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write and registered read share one edge; the read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

  // The pointer scheme never reads the slot being written in the same cycle.
  a_no_rw_collision: assert property (@(posedge clock) !(wr_en && rd_en && (wr_addr == rd_addr)));

endmodule

// File: rtl/zbt_bitstream_writer.sv
// rtl/zbt_bitstream_writer.sv - packs a byte stream MSB-first into words and drains them to ZBT SRAM
module zbt_bitstream_writer
  import zbt_bitstream_writer_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = BITSTR_BUFFER_ADDR_WIDTH,
  parameter int BUFFER_SLACK      = BITSTR_BUFFER_SLACK,
  parameter int ZBT_ADDR_WIDTH    = BITSTR_ZBT_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ZBT_Reset_Address_I,
  input  logic                      Byte_Valid_I,
  input  logic [7:0]                Byte_Data_I,
  output logic                      Byte_Ready_O,
  input  logic                      Flush_I,
  output logic                      Flush_Done_O,
  input  logic                      ZBT_Busy_I,
  output logic                      ZBT_Write_En_O,
  output logic [ZBT_ADDR_WIDTH-1:0] ZBT_Address_O,
  output logic [31:0]               ZBT_Data_O,
  output logic [ZBT_ADDR_WIDTH-1:0] Words_Written_O
);

  localparam int PW = BUFFER_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** BUFFER_ADDR_WIDTH);
  localparam logic [PW-1:0] SLACK = PW'(BUFFER_SLACK);

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_FETCH = 2'd1,
    DRAIN_WRITE = 2'd2
  } drain_state_t;

  logic                      srst;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic [31:0]               pack_q, pack_d;
  logic                      push_valid_q, push_valid_d;
  logic [31:0]               push_data_q, push_data_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  drain_state_t              state_q, state_d;
  logic [ZBT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               data_q, data_d;
  logic [ZBT_ADDR_WIDTH-1:0] count_q, count_d;
  logic                      flush_active_q, flush_active_d;
  logic                      flush_done_q, flush_done_d;

  logic [PW-1:0]             occupancy;
  logic [PW-1:0]             free_words;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      ready_int;
  logic                      accept;
  logic                      flush_start;
  logic                      pop;
  logic                      drain_idle;
  logic [31:0]               ram_rd_data;
  logic [31:0]               word_acc;
  logic [1:0]                cnt_acc;

  assign srst        = reset | ZBT_Reset_Address_I;
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign free_words  = DEPTH - occupancy;
  assign fifo_empty  = (occupancy == '0);
  assign fifo_full   = (occupancy == DEPTH);
  assign ready_int   = (free_words >= SLACK) & ~flush_active_q;
  assign accept      = Byte_Valid_I & ready_int;
  assign flush_start = Flush_I & ~flush_active_q;
  assign drain_idle  = ~push_valid_q & (byte_cnt_q == 2'd0) & fifo_empty & (state_q == DRAIN_IDLE);
  assign wr_ptr_d    = wr_ptr_q + PW'(push_valid_q);

  // Pack accepted bytes into lanes; a completed or flushed word goes to the push stage.
  always_comb begin
    word_acc     = accept ? set_lane(pack_q, byte_cnt_q, Byte_Data_I) : pack_q;
    cnt_acc      = byte_cnt_q + {1'b0, accept};
    pack_d       = word_acc;
    byte_cnt_d   = cnt_acc;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    if ((accept && (byte_cnt_q == 2'd3)) || (flush_start && (cnt_acc != 2'd0))) begin
      push_valid_d = 1'b1;
      push_data_d  = word_acc;
      pack_d       = '0;
      byte_cnt_d   = 2'd0;
    end
  end

  // Drain FSM: fetch one word from the buffer, then hold it on the ZBT port until not busy.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRAIN_FETCH;
        end
      end
      DRAIN_FETCH: begin
        data_d  = ram_rd_data;
        state_d = DRAIN_WRITE;
      end
      DRAIN_WRITE: begin
        if (!ZBT_Busy_I) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRAIN_FETCH;
          end else begin
            state_d = DRAIN_IDLE;
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Flush stays active until everything already accepted has been written out.
  always_comb begin
    flush_done_d   = flush_active_q & drain_idle;
    flush_active_d = flush_active_q;
    if (flush_start) begin
      flush_active_d = 1'b1;
    end else if (flush_done_d) begin
      flush_active_d = 1'b0;
    end
  end

  // State registers; either reset source discards all pending data.
  always_ff @(posedge clock) begin
    if (srst) begin
      byte_cnt_q     <= 2'd0;
      pack_q         <= '0;
      push_valid_q   <= 1'b0;
      push_data_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      state_q        <= DRAIN_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      count_q        <= '0;
      flush_active_q <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      pack_q         <= pack_d;
      push_valid_q   <= push_valid_d;
      push_data_q    <= push_data_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      count_q        <= count_d;
      flush_active_q <= flush_active_d;
      flush_done_q   <= flush_done_d;
    end
  end

  bitstream_wr_fifo_ram #(
    .ADDR_WIDTH (BUFFER_ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_fifo_ram (
    .clock   (clock),
    .wr_en   (push_valid_q & ~srst),
    .wr_addr (wr_ptr_q[BUFFER_ADDR_WIDTH-1:0]),
    .wr_data (push_data_q),
    .rd_en   (pop & ~srst),
    .rd_addr (rd_ptr_q[BUFFER_ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Slack guarantees the in-flight pack word always finds a free slot.
  a_no_overflow: assert property (@(posedge clock) disable iff (srst) !(push_valid_q && fifo_full));

  assign Byte_Ready_O    = ready_int & ~srst;
  assign ZBT_Write_En_O  = (state_q == DRAIN_WRITE) & ~ZBT_Busy_I & ~srst;
  assign ZBT_Address_O   = addr_q;
  assign ZBT_Data_O      = data_q;
  assign Words_Written_O = count_q;
  assign Flush_Done_O    = flush_done_q;

endmodule

// File: tb/tb_zbt_bitstream_writer.sv
// tb/tb_zbt_bitstream_writer.sv - self-checking bench for zbt_bitstream_writer
module tb_zbt_bitstream_writer;

  localparam int AW          = 8;
  localparam int BYTE_BUDGET = 200;
  localparam int DRAIN_BUDGET = 3000;

  logic          clock = 1'b0;
  logic          reset;
  logic          ZBT_Reset_Address_I;
  logic          Byte_Valid_I;
  logic [7:0]    Byte_Data_I;
  logic          Byte_Ready_O;
  logic          Flush_I;
  logic          Flush_Done_O;
  logic          ZBT_Busy_I;
  logic          ZBT_Write_En_O;
  logic [AW-1:0] ZBT_Address_O;
  logic [31:0]   ZBT_Data_O;
  logic [AW-1:0] Words_Written_O;

  always #5 clock = ~clock;

  zbt_bitstream_writer #(
    .ZBT_ADDR_WIDTH (AW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .ZBT_Reset_Address_I (ZBT_Reset_Address_I),
    .Byte_Valid_I        (Byte_Valid_I),
    .Byte_Data_I         (Byte_Data_I),
    .Byte_Ready_O        (Byte_Ready_O),
    .Flush_I             (Flush_I),
    .Flush_Done_O        (Flush_Done_O),
    .ZBT_Busy_I          (ZBT_Busy_I),
    .ZBT_Write_En_O      (ZBT_Write_En_O),
    .ZBT_Address_O       (ZBT_Address_O),
    .ZBT_Data_O          (ZBT_Data_O),
    .Words_Written_O     (Words_Written_O)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            errors = 0;
  int            checks = 0;
  int            stalls = 0;
  logic [AW-1:0] push_addr;
  logic [31:0]   part;
  int            part_n;
  logic [31:0]   mem [0:(2**AW)-1];
  logic [7:0]    stream [0:1023];
  logic          prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    push_addr = '0;
    part      = '0;
    part_n    = 0;
  endtask

  task automatic model_push();
    exp_q.push_back('{addr: push_addr, data: part});
    push_addr = push_addr + 1'b1;
    part      = '0;
    part_n    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_model();
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    Byte_Valid_I = 1'b1;
    Byte_Data_I  = b;
    while (Byte_Ready_O !== 1'b1 && t < BYTE_BUDGET) begin
      step();
      t++;
    end
    stalls += t;
    if (t >= BYTE_BUDGET) begin
      chk("byte_accept_timeout", 32'(t), 32'(BYTE_BUDGET - 1));
    end
    part[31-8*part_n -: 8] = b;
    part_n++;
    if (part_n == 4) model_push();
    step();
    Byte_Valid_I = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < DRAIN_BUDGET) begin
      step();
      t++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  // Scoreboard: every strobe must match the next expected (address, data) pair.
  always begin
    @(negedge clock);
    #2;
    if (ZBT_Busy_I === 1'b1) chk("no_strobe_while_busy", 32'(ZBT_Write_En_O), 32'd0);
    if (ZBT_Write_En_O === 1'b1) begin
      chk("strobe_one_cycle", 32'(prev_we), 32'd0);
      mem[ZBT_Address_O] = ZBT_Data_O;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(ZBT_Address_O), 32'(mon_e.addr));
        chk("write_data", ZBT_Data_O, mon_e.data);
        chk("words_written_at_strobe", 32'(Words_Written_O), 32'(mon_e.addr));
      end
    end
    prev_we = ZBT_Write_En_O;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w;
    int          t;

    reset               = 1'b1;
    ZBT_Reset_Address_I = 1'b0;
    Byte_Valid_I        = 1'b0;
    Byte_Data_I         = 8'h00;
    Flush_I             = 1'b0;
    ZBT_Busy_I          = 1'b0;
    clear_model();
    step();
    step();
    chk("reset_addr", 32'(ZBT_Address_O), 32'd0);
    chk("reset_data", ZBT_Data_O, 32'd0);
    chk("reset_words", 32'(Words_Written_O), 32'd0);
    chk("reset_we", 32'(ZBT_Write_En_O), 32'd0);
    chk("reset_done", 32'(Flush_Done_O), 32'd0);
    chk("reset_ready", 32'(Byte_Ready_O), 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(Byte_Ready_O), 32'd1);

    // Two full words, no busy.
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    drain();
    chk("words_after_two", 32'(Words_Written_O), 32'd2);

    // Partial word then flush.
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    Flush_I = 1'b1;
    model_push();
    step();
    Flush_I = 1'b0;
    t = 0;
    while (Flush_Done_O !== 1'b1 && t < 50) begin
      chk("ready_low_during_flush", 32'(Byte_Ready_O), 32'd0);
      step();
      t++;
    end
    chk("flush_done_seen", 32'(Flush_Done_O), 32'd1);
    chk("flush_written_before_done", 32'(exp_q.size()), 32'd0);
    chk("ready_at_flush_done", 32'(Byte_Ready_O), 32'd1);
    step();
    chk("flush_done_single", 32'(Flush_Done_O), 32'd0);
    chk("words_after_flush", 32'(Words_Written_O), 32'd1);

    // Flush with nothing pending completes two cycles later.
    step();
    Flush_I = 1'b1;
    step();
    Flush_I = 1'b0;
    chk("empty_flush_done_c1", 32'(Flush_Done_O), 32'd0);
    step();
    chk("empty_flush_done_c2", 32'(Flush_Done_O), 32'd1);
    step();
    chk("empty_flush_done_c3", 32'(Flush_Done_O), 32'd0);

    // Fill under busy: 64 bytes fit exactly, then backpressure.
    do_reset();
    ZBT_Busy_I = 1'b1;
    stalls = 0;
    for (int i = 0; i < 64; i++) send_byte(8'(i * 3 + 1));
    chk("busy_fill_no_stalls", 32'(stalls), 32'd0);
    step();
    chk("ready_low_when_nearly_full", 32'(Byte_Ready_O), 32'd0);
    step();
    chk("ready_stays_low", 32'(Byte_Ready_O), 32'd0);
    ZBT_Busy_I = 1'b0;
    drain();
    chk("words_after_busy_fill", 32'(Words_Written_O), 32'd16);

    // Address restart mid-stream discards everything pending.
    ZBT_Busy_I = 1'b1;
    for (int i = 0; i < 18; i++) send_byte(8'(8'h40 + i));
    repeat (6) step();
    chk("data_held_under_busy", ZBT_Data_O, 32'h40414243);
    chk("addr_held_under_busy", 32'(ZBT_Address_O), 32'd16);
    ZBT_Reset_Address_I = 1'b1;
    ZBT_Busy_I          = 1'b0;
    step();
    chk("restart_addr", 32'(ZBT_Address_O), 32'd0);
    chk("restart_data", ZBT_Data_O, 32'd0);
    chk("restart_words", 32'(Words_Written_O), 32'd0);
    chk("restart_we", 32'(ZBT_Write_En_O), 32'd0);
    chk("restart_done", 32'(Flush_Done_O), 32'd0);
    ZBT_Reset_Address_I = 1'b0;
    clear_model();
    repeat (10) step();
    chk("ready_after_restart", 32'(Byte_Ready_O), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    drain();
    chk("words_after_restart", 32'(Words_Written_O), 32'd1);

    // Loopback of 1 KB random data with random busy, then address wrap.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      stream[i]  = 8'($urandom);
      ZBT_Busy_I = ($urandom_range(0, 3) == 0);
      send_byte(stream[i]);
    end
    ZBT_Busy_I = 1'b0;
    drain();
    for (int i = 0; i < 256; i++) begin
      exp_w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
      chk("loopback_word", mem[i], exp_w);
    end
    chk("words_wrapped", 32'(Words_Written_O), 32'd0);
    chk("addr_wrapped", 32'(ZBT_Address_O), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hE0 + i));
    drain();
    chk("words_after_wrap", 32'(Words_Written_O), 32'd2);
    chk("mem_after_wrap", mem[1], 32'hE4E5E6E7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
